// File: rtl/keycode_pkg.sv
// Shared definitions for the keycode dispatch block: HID usage codes for the
// movement/fire keys, the report collector state encoding and a slot helper.
package keycode_pkg;

  localparam int REPORT_BYTES_DEFAULT = 8;
  localparam int NUM_SLOTS            = 6;
  localparam int FIRST_SLOT_BYTE      = 2;

  localparam logic [7:0] KEY_A        = 8'h04;
  localparam logic [7:0] KEY_D        = 8'h07;
  localparam logic [7:0] KEY_S        = 8'h16;
  localparam logic [7:0] KEY_W        = 8'h1A;
  localparam logic [7:0] KEY_RIGHT    = 8'h4F;
  localparam logic [7:0] KEY_LEFT     = 8'h50;
  localparam logic [7:0] KEY_DOWN     = 8'h51;
  localparam logic [7:0] KEY_UP       = 8'h52;
  localparam logic [7:0] KEY_SPACE    = 8'h2C;
  localparam logic [7:0] KEY_ENTER    = 8'h28;
  localparam logic [7:0] KEY_ROLLOVER = 8'h01;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_COMMIT  = 2'd2
  } kd_state_t;

  // True when the key is held in any slot of a report that is not a rollover
  // report (a rollover report counts as no keys pressed).
  function automatic logic key_held(input logic [8*NUM_SLOTS-1:0] slots,
                                    input logic [7:0] key);
    logic hit;
    logic roll;
    hit  = 1'b0;
    roll = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (slots[s*8 +: 8] == key)          hit  = 1'b1;
      if (slots[s*8 +: 8] == KEY_ROLLOVER) roll = 1'b1;
    end
    return hit & ~roll;
  endfunction

endpackage

// File: rtl/player_key_select.sv
// Priority scan of the six committed key slots against one player's four-key
// set. The lowest-numbered matching slot wins; a rollover code anywhere in the
// report forces the result to 00.
module player_key_select
  import keycode_pkg::*;
#(
  parameter logic [31:0] KEY_SET = 32'h0
) (
  input  logic [47:0] slots_i,
  output logic [7:0]  key_o
);

  logic found;
  logic rollover;

  // First matching slot in scan order, cleared on rollover.
  always_comb begin
    key_o    = 8'h00;
    found    = 1'b0;
    rollover = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (slots_i[s*8 +: 8] == KEY_ROLLOVER) rollover = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (!found && (slots_i[s*8 +: 8] == KEY_SET[k*8 +: 8])) begin
          key_o = slots_i[s*8 +: 8];
          found = 1'b1;
        end
      end
    end
    if (rollover) key_o = 8'h00;
  end

endmodule

// File: rtl/keycode_dispatch.sv
// Collects HID boot-keyboard reports from a byte stream, commits well-formed
// reports, and on each frame tick publishes one movement key per player.
// Optional feature macro: KEYCODE_DISPATCH_FIRE_KEYS_EN adds p1_fire/p2_fire,
// rising-press pulses for space (player 1) and enter (player 2).
module keycode_dispatch
  import keycode_pkg::*;
#(
  parameter int REPORT_BYTES = REPORT_BYTES_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] p1_keycode,
  output logic [7:0] p2_keycode,
`ifdef KEYCODE_DISPATCH_FIRE_KEYS_EN
  output logic       p1_fire,
  output logic       p2_fire,
`endif
  output logic       rpt_err
);

  localparam int                IDX_W    = $clog2(REPORT_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REPORT_BYTES - 1);

  kd_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic [47:0]      shadow_q;
  logic [47:0]      commit_q;
  logic             frame_q;
  logic             tick_w;
  logic             accept;
  logic [7:0]       p1_sel, p2_sel;
  logic [7:0]       p1_key_q, p2_key_q;

  assign accept = in_valid & in_ready;
  assign tick_w = frame_clk & ~frame_q;

  // State register with the byte index and error pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_COLLECT;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Next state: frame the report, flag short/long reports.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          if (in_last) begin
            idx_d = '0;
            if (idx_q == LAST_IDX) state_d = ST_COMMIT;
            else                   err_d   = 1'b1;
          end else if (idx_q == LAST_IDX) begin
            // Report ran past its length: discard the rest up to in_last.
            idx_d   = '0;
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (accept && in_last) begin
          idx_d   = '0;
          state_d = ST_COLLECT;
        end
      end
      ST_COMMIT: state_d = ST_COLLECT;
      default:   state_d = ST_COLLECT;
    endcase
  end

  // Outputs decoded from the state: stall input only during the commit cycle.
  always_comb begin
    in_ready = (state_q != ST_COMMIT);
  end

  assign rpt_err = err_q;

  // Shadow slots capture bytes 2..7; committed slots take them on COMMIT.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shadow_q <= '0;
      commit_q <= '0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if ((s + FIRST_SLOT_BYTE) < REPORT_BYTES && state_q == ST_COLLECT &&
            accept && idx_q == IDX_W'(s + FIRST_SLOT_BYTE)) begin
          shadow_q[s*8 +: 8] <= in_data;
        end
      end
      if (state_q == ST_COMMIT) commit_q <= shadow_q;
    end
  end

  player_key_select #(.KEY_SET({KEY_A, KEY_D, KEY_S, KEY_W})) u_p1_sel (
    .slots_i (commit_q),
    .key_o   (p1_sel)
  );

  player_key_select #(.KEY_SET({KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP})) u_p2_sel (
    .slots_i (commit_q),
    .key_o   (p2_sel)
  );

  // Frame-tick edge detect and per-frame keycode latch.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q  <= 1'b0;
      p1_key_q <= 8'h00;
      p2_key_q <= 8'h00;
    end else begin
      frame_q <= frame_clk;
      if (tick_w) begin
        p1_key_q <= p1_sel;
        p2_key_q <= p2_sel;
      end
    end
  end

  assign p1_keycode = p1_key_q;
  assign p2_keycode = p2_key_q;

`ifdef KEYCODE_DISPATCH_FIRE_KEYS_EN
  logic space_now, enter_now;
  logic space_prev_q, enter_prev_q;
  logic p1_fire_q, p2_fire_q;

  assign space_now = key_held(commit_q, KEY_SPACE);
  assign enter_now = key_held(commit_q, KEY_ENTER);

  // Fire pulses on a tick where the key became held since the previous tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      space_prev_q <= 1'b0;
      enter_prev_q <= 1'b0;
      p1_fire_q    <= 1'b0;
      p2_fire_q    <= 1'b0;
    end else begin
      p1_fire_q <= tick_w & space_now & ~space_prev_q;
      p2_fire_q <= tick_w & enter_now & ~enter_prev_q;
      if (tick_w) begin
        space_prev_q <= space_now;
        enter_prev_q <= enter_now;
      end
    end
  end

  assign p1_fire = p1_fire_q;
  assign p2_fire = p2_fire_q;
`endif

endmodule

// File: tb/tb_keycode_dispatch.sv
// Bench for keycode_dispatch: table of reports with expected per-player keys,
// plus hand sequences for malformed reports, commit/tick collision, reset
// mid-report and (when enabled) fire pulses.
module tb_keycode_dispatch;

  logic       clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic [7:0] p1_keycode, p2_keycode;
  logic       rpt_err;
`ifdef KEYCODE_DISPATCH_FIRE_KEYS_EN
  logic       p1_fire, p2_fire;
`endif

  always #5 clk = ~clk;

  keycode_dispatch #(.REPORT_BYTES(8)) dut (
    .Clk        (clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .p1_keycode (p1_keycode),
    .p2_keycode (p2_keycode),
`ifdef KEYCODE_DISPATCH_FIRE_KEYS_EN
    .p1_fire    (p1_fire),
    .p2_fire    (p2_fire),
`endif
    .rpt_err    (rpt_err)
  );

  int checks = 0;
  int passed = 0;
  int err_cnt = 0;
  int fire1_cnt = 0;
  int fire2_cnt = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    logic [47:0] slots;
    logic [7:0]  e1;
    logic [7:0]  e2;
  } vec_t;
  vec_t vecs[8];

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (rpt_err) err_cnt++;
`ifdef KEYCODE_DISPATCH_FIRE_KEYS_EN
    if (p1_fire) fire1_cnt++;
    if (p2_fire) fire2_cnt++;
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  function automatic logic [47:0] mk(input logic [7:0] s0, s1, s2, s3, s4, s5);
    return {s5, s4, s3, s2, s1, s0};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int guard;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_report(input logic [47:0] slots, input int n, input int last_at);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = (k >= 2 && k <= 7) ? slots[(k-2)*8 +: 8] : 8'h00;
      send_byte(b, k == last_at);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Raise frame_clk; the keycodes must update one clock later.
  task automatic tick(input logic [7:0] e1, input logic [7:0] e2);
    logic [15:0] got;
    exp_q.push_back({e1, e2});
    frame_clk = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      check("p1_keycode", {24'h0, p1_keycode}, {24'h0, got[15:8]});
      check("p2_keycode", {24'h0, p2_keycode}, {24'h0, got[7:0]});
    end
    frame_clk = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 Reset = 1'b0;
  endtask

  int e0, f0, g0;

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;

    vecs[0] = '{mk(8'h1A, 8'h52, 8'h00, 8'h00, 8'h00, 8'h00), 8'h1A, 8'h52};
    vecs[1] = '{mk(8'h07, 8'h04, 8'h50, 8'h00, 8'h00, 8'h00), 8'h07, 8'h50};
    vecs[2] = '{mk(8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01), 8'h00, 8'h00};
    vecs[3] = '{mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h16, 8'h51), 8'h16, 8'h51};
    vecs[4] = '{mk(8'h2C, 8'h28, 8'h4F, 8'h00, 8'h00, 8'h04), 8'h04, 8'h4F};
    vecs[5] = '{mk(8'h52, 8'h1A, 8'h01, 8'h00, 8'h00, 8'h00), 8'h00, 8'h00};
    vecs[6] = '{mk(8'h05, 8'h50, 8'h4F, 8'h07, 8'h1A, 8'h00), 8'h07, 8'h50};
    vecs[7] = '{mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h52), 8'h00, 8'h52};

    do_reset(3);
    @(negedge clk);
    check("reset_p1", {24'h0, p1_keycode}, 32'h00);
    check("reset_p2", {24'h0, p2_keycode}, 32'h00);
    check("reset_ready", {31'h0, in_ready}, 32'd1);
    check("reset_err", {31'h0, rpt_err}, 32'd0);
    @(posedge clk); #1;
    tick(8'h00, 8'h00);

    // Table: each report commits, then one tick publishes it.
    for (int i = 0; i < 8; i++) begin
      send_report(vecs[i].slots, 8, 7);
      @(negedge clk);
      check("commit_ready_low", {31'h0, in_ready}, 32'd0);
      @(negedge clk);
      check("commit_ready_back", {31'h0, in_ready}, 32'd1);
      @(posedge clk); #1;
      tick(vecs[i].e1, vecs[i].e2);
    end

    // Hold across ticks with no new report.
    send_report(vecs[0].slots, 8, 7);
    idle(2);
    tick(8'h1A, 8'h52);
    for (int i = 0; i < 3; i++) tick(8'h1A, 8'h52);

    // Short report: one error pulse, outputs unchanged.
    e0 = err_cnt;
    send_report(mk(8'h04, 8'h4F, 8'h00, 8'h00, 8'h00, 8'h00), 5, 4);
    idle(3);
    check("short_err", err_cnt, e0 + 1);
    tick(8'h1A, 8'h52);

    // Long report: one error pulse, remainder drained, next report clean.
    e0 = err_cnt;
    send_report(mk(8'h07, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00), 10, 9);
    idle(3);
    check("long_err", err_cnt, e0 + 1);
    tick(8'h1A, 8'h52);
    send_report(mk(8'h16, 8'h4F, 8'h00, 8'h00, 8'h00, 8'h00), 8, 7);
    idle(2);
    tick(8'h16, 8'h4F);
    check("long_recover_err", err_cnt, e0 + 1);

    // Commit and tick in the same cycle: old keys first, new keys next tick.
    send_report(mk(8'h04, 8'h51, 8'h00, 8'h00, 8'h00, 8'h00), 8, 7);
    tick(8'h16, 8'h4F);
    idle(1);
    tick(8'h04, 8'h51);

    // Reset mid-report drops the partial bytes and clears the outputs.
    e0 = err_cnt;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h07, 1'b0);
    do_reset(2);
    @(negedge clk);
    check("midrst_p1", {24'h0, p1_keycode}, 32'h00);
    check("midrst_p2", {24'h0, p2_keycode}, 32'h00);
    @(posedge clk); #1;
    send_report(mk(8'h1A, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00), 8, 7);
    idle(2);
    tick(8'h1A, 8'h50);
    check("midrst_err", err_cnt, e0);

    // Fire sequences; movement keys checked in every build.
    f0 = fire1_cnt;
    g0 = fire2_cnt;
    send_report(mk(8'h2C, 8'h1A, 8'h00, 8'h00, 8'h00, 8'h00), 8, 7);
    idle(2);
    for (int i = 0; i < 3; i++) tick(8'h1A, 8'h00);
`ifdef KEYCODE_DISPATCH_FIRE_KEYS_EN
    check("fire1_held_once", fire1_cnt, f0 + 1);
`endif
    send_report(mk(8'h1A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8, 7);
    idle(2);
    tick(8'h1A, 8'h00);
    send_report(mk(8'h00, 8'h2C, 8'h04, 8'h00, 8'h00, 8'h00), 8, 7);
    idle(2);
    tick(8'h04, 8'h00);
`ifdef KEYCODE_DISPATCH_FIRE_KEYS_EN
    check("fire1_repress", fire1_cnt, f0 + 2);
`endif
    send_report(mk(8'h28, 8'h52, 8'h00, 8'h00, 8'h00, 8'h00), 8, 7);
    idle(2);
    tick(8'h00, 8'h52);
    tick(8'h00, 8'h52);
`ifdef KEYCODE_DISPATCH_FIRE_KEYS_EN
    check("fire2_once", fire2_cnt, g0 + 1);
    check("fire1_no_extra", fire1_cnt, f0 + 2);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/keycode_dispatch.md
# keycode_dispatch

- Producer side of the per-player keycode interface consumed by the tank movement blocks.
- Accepts USB HID boot-keyboard reports as a byte stream from the USB host interface.
- Extracts one movement keycode per player and updates both player buses only on frame ticks, so each tank sees a keycode that is stable for a whole frame.
- Sits between the keyboard host logic and the two tank instances.

## Interface
- `REPORT_BYTES`, default 8: bytes per HID report (modifier, reserved, 6 key slots).
- `Clk`, in, 1: system clock.
- `Reset`, in, 1: synchronous, active-high reset.
- `frame_clk`, in, 1: frame strobe, synchronous to `Clk`; the rising edge is the frame tick.
- `in_valid`, in, 1: report byte valid.
- `in_data`, in, 8: report byte.
- `in_last`, in, 1: last byte of the report.
- `in_ready`, out, 1: byte accepted when `in_valid && in_ready`.
- `p1_keycode`, out, 8: player 1 movement key. One of 04, 07, 16, 1A (A/D/S/W), or 00.
- `p2_keycode`, out, 8: player 2 movement key. One of 4F, 50, 51, 52 (arrows), or 00.
- `rpt_err`, out, 1: one-cycle pulse when a malformed report is dropped.
- `p1_fire`, out, 1 (FIRE_KEYS_EN only): one-cycle pulse.
- `p2_fire`, out, 1 (FIRE_KEYS_EN only): one-cycle pulse.

## Operation
- **States:**
  - **COLLECT:** `in_ready=1`. A byte index counts accepted bytes. Bytes 2..7 are written to the shadow slot registers.
  - **DRAIN:** entered when a report exceeds `REPORT_BYTES` without `in_last`. `in_ready=1`; bytes are discarded until `in_last`.
  - **COMMIT:** single cycle, `in_ready=0`. Shadow slots copy to the committed slots, then the block returns to COLLECT.
- **Transitions:**
  - Accepted `in_last` at index `REPORT_BYTES-1`: go to COMMIT.
  - Accepted `in_last` at any other index: drop the report, pulse `rpt_err`, reset the index, stay in COLLECT.
  - Index reaches `REPORT_BYTES` without `in_last`: pulse `rpt_err`, go to DRAIN.
  - DRAIN with accepted `in_last`: index = 0, return to COLLECT.
- **Player selection** (combinational over the committed slots):
  - Scan slot 0 to slot 5; the first slot whose value is in the player's set wins.
  - If no slot matches, the result is 00.
  - Slots holding 01 (rollover error) mean the whole report is treated as all-zero.
- **Frame tick:** a registered copy of `frame_clk` gives edge = `frame_clk & ~prev`. On edge, `p1_keycode` and `p2_keycode` load the selection results.
- **Reset values:**
  - `p1_keycode` = `p2_keycode` = 00.
  - Committed and shadow slots = 00.
  - State = COLLECT, index = 0.
  - `in_ready` = 1.
  - `rpt_err` = 0, fire outputs = 0.
- Reset in the middle of a report drops the partial report. The next accepted byte is treated as byte 0.

## Timing
- `in_ready` goes low for exactly the one cycle after an accepted `in_last` (the COMMIT cycle).
- Committed slots are valid from the cycle after COMMIT.
- Keycode outputs change only in the cycle after the cycle where the edge is detected. Latency from `frame_clk` rising to output change is 1 `Clk`.
- If COMMIT and the edge fall in the same cycle, the outputs use the previously committed slots. The new report takes effect at the next tick.
- With no new report, the outputs hold their values across ticks.
- `rpt_err` is asserted in the cycle after the offending byte is accepted.

## Configuration
- `KEYCODE_DISPATCH_FIRE_KEYS_EN` defined:
  - `p1_fire`/`p2_fire` exist.
  - `p1_fire` pulses for 1 cycle, coincident with the keycode update, on a frame tick where 2C (space) is in any committed slot and was absent at the previous tick.
  - `p2_fire` does the same for 28 (enter).
- Macro undefined: the fire ports and their logic are absent. 2C and 28 are ignored.

## Structure
- Package `keycode_pkg` holds:
  - Key constants: `KEY_A`, `KEY_D`, `KEY_S`, `KEY_W`, `KEY_LEFT`, `KEY_RIGHT`, `KEY_DOWN`, `KEY_UP`, `KEY_SPACE`, `KEY_ENTER`, `KEY_ROLLOVER`.
  - The state enum `kd_state_t`.
  - `REPORT_BYTES_DEFAULT`.
- Sub-module `player_key_select`: combinational priority scan of 6 slots against a 4-entry key set (set passed as a parameter). Instantiated twice, once per player.

## Test plan
- **Reset and first tick:** reset, then a tick with no report → both keycodes 00, `in_ready`=1, `rpt_err`=0.
- **Two-player report:** report 00 00 1A 52 00 00 00 00, then a tick → `p1_keycode`=1A, `p2_keycode`=52 one cycle after the edge. Values hold over 3 further ticks.
- **Priority:** slots 07 04 50 → p1=07, p2=50. Then report all-01 → both 00 at the next tick.
- **Malformed reports:**
  - 5-byte report with `in_last` → `rpt_err` pulse, outputs unchanged.
  - 10-byte report without `in_last` until byte 10 → one `rpt_err` pulse, bytes drained, next valid report commits normally.
- **Commit/tick collision:** COMMIT coincides with a tick → old values persist, new values appear at the following tick. A reset asserted mid-report drops the partial report, and a subsequent full report is decoded correctly.
- **Fire (FIRE_KEYS_EN defined):**
  - Space is held across 3 ticks → `p1_fire` pulses once.
  - Space is released, then pressed again → second pulse.
  - With the macro undefined, the same stimulus still produces correct movement keycodes.
